// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a client and the serial adder controller.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (output start, op_a, op_b, input busy, done, result, cout);
  modport slave  (input start, op_a, op_b, output busy, done, result, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// Sequences an external one-bit serial Mealy adder over WIDTH operand bits,
// LSB first, and collects the sum and final carry.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  serial_add_ctrl_if.slave bus,
  output logic             add_rst,
  output logic             add_a,
  output logic             add_b,
  input  logic             sum_bit,
  input  logic             carry_bit
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic             cout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (bus.start) begin
          sh_a <= bus.op_a;
          sh_b <= bus.op_b;
          res  <= '0;
          cnt  <= '0;
        end
        SHIFT: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          // Sum enters at the MSB so bit 0 lands in res[0] after WIDTH shifts.
          res  <= {sum_bit, res[WIDTH-1:1]};
          cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        DONE:  cout_q <= carry_bit;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = CLEAR;
      CLEAR: state_nx = SHIFT;
      SHIFT: if (cnt == LAST) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = res;
  // The adder's carry is already final in DONE, so present it during the pulse.
  assign bus.cout   = (state == DONE) ? carry_bit : cout_q;
  assign add_rst    = reset | (state == CLEAR);
  assign add_a      = (state == SHIFT) & sh_a[0];
  assign add_b      = (state == SHIFT) & sh_b[0];

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Drives directed additions through the controller and a serial Mealy adder,
// checking every cycle against a phase-based model of the operation.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  logic add_rst, add_a, add_b, sum_bit, carry_bit;
  logic q;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .add_rst(add_rst), .add_a(add_a), .add_b(add_b),
    .sum_bit(sum_bit), .carry_bit(carry_bit)
  );

  always #5 clk = ~clk;

  // Serial full adder: combinational sum, registered carry.
  always @(posedge clk or posedge add_rst)
    if (add_rst) q <= 1'b0;
    else         q <= (add_a & add_b) | (add_a & q) | (add_b & q);
  assign sum_bit   = add_a ^ add_b ^ q;
  assign carry_bit = q;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase -1 idle, 0 clear, 1..W bit (phase-1), W+1 done.
  int         phase;
  logic [W-1:0] ma, mb;
  logic       have_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase = -1; have_res = 1'b0; ma = '0; mb = '0;
    end else if (phase < 0) begin
      if (bus.start) begin
        ma = bus.op_a; mb = bus.op_b; phase = 0; have_res = 1'b0;
      end
    end else if (phase == W + 1) begin
      phase = -1; have_res = 1'b1;
    end else begin
      phase++;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int s, n, pr;
    s = int'(ma) + int'(mb);
    if (bus.done) done_cnt++;
    chk("busy", bus.busy, phase >= 0);
    chk("done", bus.done, phase == W + 1);
    chk("add_rst", add_rst, reset || phase == 0);
    chk("add_a", add_a, (phase >= 1 && phase <= W) ? ((int'(ma) >> (phase - 1)) & 1) : 0);
    chk("add_b", add_b, (phase >= 1 && phase <= W) ? ((int'(mb) >> (phase - 1)) & 1) : 0);
    if (phase < 0 || phase == W + 1) begin
      if (have_res || phase == W + 1) begin
        chk("result", bus.result, s & 32'hFF);
        chk("cout", bus.cout, (s >> W) & 1);
      end else begin
        chk("result", bus.result, 0);
        chk("cout", bus.cout, 0);
      end
    end else begin
      n  = (phase == 0) ? 0 : phase - 1;
      pr = (n == 0) ? 0 : (((s & ((1 << n) - 1)) << (W - n)) & 32'hFF);
      chk("result_partial", bus.result, pr);
    end
  end

  // Waits (bounded) for done; returns edges since the acceptance edge plus one.
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.done && n < 30) begin
      @(posedge clk); #2; n++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input string nm);
    int n;
    @(posedge clk); #2; bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #2; bus.start = 1'b0; bus.op_a = ~a; bus.op_b = ~b;
    wait_done(n);
    chk({nm, "_lat"}, n, W + 2);
    #3;
    chk({nm, "_res"}, bus.result, er);
    chk({nm, "_cout"}, bus.cout, ec);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, d0;
    int t[3];
    reset = 1'b1; bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_addrst", add_rst, 1);
    #1 reset = 1'b0;

    run_op(8'h05, 8'h03, 8'h08, 1'b0, "add_5_3");
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_1");
    run_op(8'h00, 8'h00, 8'h00, 1'b0, "add_0_0");

    // Start pulsed mid-operation must be ignored.
    @(posedge clk); #2; bus.start = 1'b1; bus.op_a = 8'hFF; bus.op_b = 8'hFF;
    @(posedge clk); #2; bus.start = 1'b0; d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2; bus.start = 1'b1; bus.op_a = 8'h11; bus.op_b = 8'h22;
    @(posedge clk); #2; bus.start = 1'b0;
    wait_done(n);
    chk("ign_res", bus.result, 8'hFE);
    chk("ign_cout", bus.cout, 1);
    repeat (6) @(posedge clk);
    #2;
    chk("ign_pulses", done_cnt - d0, 1);

    // Reset in SHIFT cycle 3 of 0xAA+0x55 aborts immediately.
    @(posedge clk); #2; bus.start = 1'b1; bus.op_a = 8'hAA; bus.op_b = 8'h55;
    @(posedge clk); #2; bus.start = 1'b0; d0 = done_cnt;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_res", bus.result, 0);
    chk("abort_addrst", add_rst, 1);
    @(posedge clk); #2 reset = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("abort_nodone", done_cnt - d0, 0);
    run_op(8'h0F, 8'h01, 8'h10, 1'b0, "after_rst");

    // Start held high: back-to-back operations.
    @(posedge clk); #2; bus.start = 1'b1; bus.op_a = 8'h80; bus.op_b = 8'h80;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!bus.done && n < 30) begin @(posedge clk); #2; n++; end
      t[k] = cyc;
      chk("b2b_res", bus.result, 8'h00);
      chk("b2b_cout", bus.cout, 1);
      if (k == 2) bus.start = 1'b0;
      @(posedge clk); #2;
    end
    chk("b2b_gap1", t[1] - t[0], W + 3);
    chk("b2b_gap2", t[2] - t[1], W + 3);
    repeat (3) @(posedge clk);
    #4;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  operand A.
REQ-006 op_b  input  WIDTH  operand B.
REQ-007 busy  output  1  high in CLEAR, SHIFT and DONE.
REQ-008 done  output  1  one-cycle pulse; result and cout valid.
REQ-009 result  output  WIDTH  sum bits of last completed addition.
REQ-010 cout  output  1  carry-out of last completed addition.
REQ-011 add_rst  output  1  drives the serial adder's async active-high reset.
REQ-012 add_a  output  1  serial bit of A to adder, LSB first.
REQ-013 add_b  output  1  serial bit of B to adder, LSB first.
REQ-014 sum_bit  input  1  adder's combinational (Mealy) sum output.
REQ-015 carry_bit  input  1  adder's registered carry state.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, SHIFT, DONE, with IDLE entered on reset.
REQ-017 IDLE: start=1 at a rising edge SHALL capture op_a/op_b into shift registers, clear result, and move to CLEAR; start=0 stays in IDLE.
REQ-018 CLEAR: lasts exactly one cycle with add_rst=1, clearing adder carry; then SHIFT.
REQ-019 SHIFT: lasts exactly WIDTH cycles, tracked by a bit counter 0..WIDTH-1.
REQ-020 SHIFT cycle i: add_a=A[i], add_b=B[i]; at the closing edge sum_bit SHALL be shifted into result MSB side so that after WIDTH cycles result[i] holds the sum of bit i.
REQ-021 Counter = WIDTH-1 at an edge SHALL move to DONE; counter SHALL not wrap within an operation.
REQ-022 DONE: lasts one cycle; done=1; cout SHALL be loaded from carry_bit at the closing edge; then IDLE.
REQ-023 Latency: start accepted at edge k -> done high in cycle k+WIDTH+1 .. k+WIDTH+2 (WIDTH+2 cycles after acceptance); back-to-back period WIDTH+3 cycles.
REQ-024 Outside SHIFT, add_a and add_b SHALL be 0.
REQ-025 Outside CLEAR and reset, add_rst SHALL be 0; add_rst SHALL equal 1 combinationally while reset=1.
REQ-026 start asserted while busy=1 SHALL be ignored; operands captured at acceptance SHALL NOT change mid-operation.
REQ-027 result and cout SHALL hold their values from DONE until the next accepted start.
REQ-028 Arithmetic: {cout,result} SHALL equal op_a+op_b modulo 2^(WIDTH+1).

Reset
REQ-029 While reset=1: state=IDLE, busy=0, done=0, result=0, cout=0, add_a=0, add_b=0, counter=0, operand registers=0.
REQ-030 Reset asserted mid-operation SHALL abort immediately (asynchronously); no done pulse is issued for the aborted operation.
REQ-031 After reset deasserts, the first start accepted SHALL complete normally.

Verification
REQ-032 Bench SHALL connect a serial Mealy full-adder model (sum=a^b^q, q<=maj(a,b,q), async reset) to add_* ports, WIDTH=8, 10 ns clock.
REQ-033 op_a=0x05, op_b=0x03, start 1 cycle -> done 10 cycles after acceptance, result=0x08, cout=0.
REQ-034 0xFF+0x01 -> result=0x00, cout=1; then 0x00+0x00 -> result=0x00, cout=0 (carry cleared by CLEAR).
REQ-035 0xFF+0xFF, then start pulsed with 0x11/0x22 during SHIFT -> second start ignored; result=0xFE, cout=1; only one done pulse.
REQ-036 reset asserted in 4th SHIFT cycle of 0xAA+0x55 -> busy=0, result=0, add_rst=1 immediately; after release 0x0F+0x01 -> result=0x10, cout=0.
REQ-037 start held high for 3 operations with op_a=0x80, op_b=0x80 -> done pulses exactly 11 cycles apart, each result=0x00, cout=1.
